// File: rtl/fosfor_present_pkg.sv
// ============================================================================
// Module : fosfor_present_pkg
// Brief  : Shared PRESENT constants, FSM encoding and S/P layer functions.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package fosfor_present_pkg;

  localparam int ROUNDS = 31;
  localparam int RC_W   = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2
  } fsm_e;

  function automatic logic [3:0] sbox4(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [63:0] sbox_layer64(input logic [63:0] x);
    logic [63:0] y;
    for (int n = 0; n < 16; n++) begin
      y[4*n +: 4] = sbox4(x[4*n +: 4]);
    end
    return y;
  endfunction

  // Bit i moves to (16*i) mod 63; bit 63 is a fixed point.
  function automatic logic [63:0] p_layer64(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 63; i++) begin
      y[(16*i) % 63] = x[i];
    end
    y[63] = x[63];
    return y;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fosfor_present_key_schedule.sv
// ============================================================================
// Module : fosfor_present_key_schedule
// Brief  : Combinational PRESENT key update and round-key extraction (80/128).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fosfor_present_key_schedule
  import fosfor_present_pkg::*;
#(
  parameter int KEY_BITS = 80
) (
  input  logic [KEY_BITS-1:0] i_key,
  input  logic [RC_W-1:0]     i_rc,
  output logic [63:0]         o_round_key,
  output logic [KEY_BITS-1:0] o_next_key
);

  logic [KEY_BITS-1:0] w_rot;

  assign o_round_key = i_key[KEY_BITS-1 -: 64];
  assign w_rot       = {i_key[KEY_BITS-62:0], i_key[KEY_BITS-1 -: 61]};

  generate
    if (KEY_BITS == 80) begin : g_ks80
      always_comb begin
        o_next_key          = w_rot;
        o_next_key[79:76]   = sbox4(w_rot[79:76]);
        o_next_key[19:15]   = w_rot[19:15] ^ i_rc;
      end
    end else if (KEY_BITS == 128) begin : g_ks128
      always_comb begin
        o_next_key          = w_rot;
        o_next_key[127:124] = sbox4(w_rot[127:124]);
        o_next_key[123:120] = sbox4(w_rot[123:120]);
        o_next_key[66:62]   = w_rot[66:62] ^ i_rc;
      end
    end else begin : g_ks_unsupported
      // Only reached alongside the top-level elaboration error.
      assign o_next_key = w_rot;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/fosfor_present_core.sv
// ============================================================================
// Module : fosfor_present_core
// Brief  : Iterative PRESENT-64 encryption, one round per clock, 80/128-bit key.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fosfor_present_core
  import fosfor_present_pkg::*;
#(
  parameter int KEY_BITS = 80,
  parameter int ROUNDS   = fosfor_present_pkg::ROUNDS
) (
  input  logic                Clk_k,
  input  logic                Reset_rn,
  input  logic                Start_i,
  input  logic [KEY_BITS-1:0] Key_b,
  input  logic [63:0]         PlainText_b,
  output logic                Ready_o,
  output logic                Done_o,
  output logic [63:0]         CipherText_b
);

  generate
    if (!(KEY_BITS == 80 || KEY_BITS == 128)) begin : g_bad_key_bits
      $error("fosfor_present_core: KEY_BITS=%0d is illegal, must be 80 or 128", KEY_BITS);
    end
    if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
      $error("fosfor_present_core: ROUNDS=%0d does not fit the 5-bit round counter", ROUNDS);
    end
  endgenerate

  localparam logic [RC_W-1:0] C_LAST_RC = RC_W'(ROUNDS);

  fsm_e                r_fsm;
  fsm_e                w_fsm_nxt;
  logic [63:0]         r_state;
  logic [KEY_BITS-1:0] r_key;
  logic [RC_W-1:0]     r_rc;
  logic [63:0]         r_ct;
  logic                r_done;

  logic [63:0]         w_round_key;
  logic [KEY_BITS-1:0] w_next_key;
  logic [63:0]         w_round_out;
  logic                w_last_round;

  fosfor_present_key_schedule #(
    .KEY_BITS (KEY_BITS)
  ) u_key_schedule (
    .i_key       (r_key),
    .i_rc        (r_rc),
    .o_round_key (w_round_key),
    .o_next_key  (w_next_key)
  );

  assign w_round_out  = p_layer64(sbox_layer64(r_state ^ w_round_key));
  assign w_last_round = (r_rc == C_LAST_RC);

  always_ff @(posedge Clk_k) begin
    if (!Reset_rn) begin
      r_fsm <= ST_IDLE;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      ST_IDLE:  if (Start_i)      w_fsm_nxt = ST_ROUND;
      ST_ROUND: if (w_last_round) w_fsm_nxt = ST_FINAL;
      ST_FINAL: w_fsm_nxt = ST_IDLE;
      default:  w_fsm_nxt = ST_IDLE;
    endcase
  end

  // Counter holds at the last round so it never wraps past 31.
  always_ff @(posedge Clk_k) begin
    if (!Reset_rn) begin
      r_state <= '0;
      r_key   <= '0;
      r_rc    <= '0;
      r_ct    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_fsm)
        ST_IDLE: begin
          if (Start_i) begin
            r_state <= PlainText_b;
            r_key   <= Key_b;
            r_rc    <= RC_W'(1);
          end
        end
        ST_ROUND: begin
          r_state <= w_round_out;
          r_key   <= w_next_key;
          if (!w_last_round) begin
            r_rc <= r_rc + RC_W'(1);
          end
        end
        ST_FINAL: begin
          r_ct   <= r_state ^ w_round_key;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign Ready_o      = (r_fsm == ST_IDLE);
  assign Done_o       = r_done;
  assign CipherText_b = r_ct;

endmodule

`default_nettype wire
